// File: rtl/bus_coherence_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bus_coherence_ctrl
// Description : Two-core memory bus controller with snooping coherence.
//               Serialises icache/dcache traffic onto a single-port RAM and
//               services coherent dcache misses either cache-to-cache (with
//               a simultaneous RAM writeback) or from RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_coherence_ctrl (
   input  logic              CLK,
   input  logic              nRST,
   // icache ports
   input  logic [1:0]        iREN,
   input  logic [1:0][31:0]  iaddr,
   output logic [1:0]        iwait,
   output logic [1:0][31:0]  iload,
   // dcache ports
   input  logic [1:0]        dREN,
   input  logic [1:0]        dWEN,
   input  logic [1:0][31:0]  daddr,
   input  logic [1:0][31:0]  dstore,
   output logic [1:0]        dwait,
   output logic [1:0][31:0]  dload,
   // coherence ports
   input  logic [1:0]        cctrans,
   input  logic [1:0]        ccwrite,
   output logic [1:0]        ccwait,
   output logic [1:0]        ccinv,
   output logic [1:0][31:0]  ccsnoopaddr,
   // RAM ports
   output logic              ramREN,
   output logic              ramWEN,
   output logic [31:0]       ramaddr,
   output logic [31:0]       ramstore,
   input  logic [31:0]       ramload,
   input  logic [1:0]        ramstate
);

   localparam logic [1:0] c_RAM_ACCESS = 2'd2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      IFETCH = 3'd1,
      DWB    = 3'd2,
      SNOOP  = 3'd3,
      C2C1   = 3'd4,
      C2C2   = 3'd5,
      RD1    = 3'd6,
      RD2    = 3'd7
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       r_req;         // core owning the current transaction
   logic       w_req_next;
   logic       r_last;        // last dcache grant, loses the next dcache tie
   logic       w_last_next;
   logic       r_ilast;       // last icache grant on a tie
   logic       w_ilast_next;

   logic       w_access;      // RAM completes the current word this cycle
   logic       w_oth;         // the core being snooped
   logic [1:0] w_dreq;        // per-core dcache request
   logic       w_dpick;       // dcache arbitration winner
   logic       w_ipick;       // icache arbitration winner

   assign w_access = (ramstate == c_RAM_ACCESS);
   assign w_oth    = ~r_req;

   // Arbitration winners: on a tie the core that did not win last time wins.
   always_comb begin
      w_dreq  = dREN | dWEN;
      w_dpick = (&w_dreq) ? ~r_last  : w_dreq[1];
      w_ipick = (&iREN)   ? ~r_ilast : iREN[1];
   end

   // State, grant and fairness pointers; reset aborts any transaction.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_last  <= 1'b1;
         r_ilast <= 1'b1;
      end else begin
         r_state <= w_next;
         r_req   <= w_req_next;
         r_last  <= w_last_next;
         r_ilast <= w_ilast_next;
      end
   end

   // Next-state: grant in IDLE, otherwise advance on each completed word.
   always_comb begin
      w_next       = r_state;
      w_req_next   = r_req;
      w_last_next  = r_last;
      w_ilast_next = r_ilast;
      case (r_state)
         IDLE: begin
            if (|w_dreq) begin
               w_req_next  = w_dpick;
               w_last_next = w_dpick;
               if (dWEN[w_dpick] && !cctrans[w_dpick]) begin
                  w_next = DWB;
               end else if (dREN[w_dpick]) begin
                  w_next = cctrans[w_dpick] ? SNOOP : RD1;
               end else begin
                  // a write flagged coherent is still just a word write
                  w_next = DWB;
               end
            end else if (|iREN) begin
               w_req_next   = w_ipick;
               w_ilast_next = w_ipick;
               w_next       = IFETCH;
            end
         end
         IFETCH: if (w_access) w_next = IDLE;
         DWB:    if (w_access) w_next = IDLE;
         // the snooped cache answers within the snoop cycle
         SNOOP:  w_next = (cctrans[w_oth] && ccwrite[w_oth]) ? C2C1 : RD1;
         C2C1:   if (w_access) w_next = C2C2;
         C2C2:   if (w_access) w_next = IDLE;
         RD1:    if (w_access) w_next = RD2;
         RD2:    if (w_access) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs decoded from state/grant; held at idle values while in reset.
   always_comb begin
      iwait       = 2'b11;
      dwait       = 2'b11;
      iload       = {ramload, ramload};
      dload       = {ramload, ramload};
      ccwait      = 2'b00;
      ccinv       = 2'b00;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      if (nRST) begin
         case (r_state)
            IFETCH: begin
               ramREN  = 1'b1;
               ramaddr = iaddr[r_req];
               if (w_access) iwait[r_req] = 1'b0;
            end
            DWB: begin
               ramWEN   = 1'b1;
               ramaddr  = daddr[r_req];
               ramstore = dstore[r_req];
               if (w_access) dwait[r_req] = 1'b0;
            end
            SNOOP: begin
               ccwait[w_oth]      = 1'b1;
               ccsnoopaddr[w_oth] = daddr[r_req];
               ccinv[w_oth]       = ccwrite[r_req];
            end
            C2C1, C2C2: begin
               // modified word goes to the requester and to RAM at once
               ccwait[w_oth]      = 1'b1;
               ccsnoopaddr[w_oth] = daddr[r_req];
               ccinv[w_oth]       = ccwrite[r_req];
               ramWEN             = 1'b1;
               ramaddr            = daddr[w_oth];
               ramstore           = dstore[w_oth];
               dload[r_req]       = dstore[w_oth];
               if (w_access) dwait = 2'b00;
            end
            RD1, RD2: begin
               ramREN  = 1'b1;
               ramaddr = daddr[r_req];
               if (w_access) dwait[r_req] = 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bus_coherence_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_coherence_ctrl
// Description : Bench for bus_coherence_ctrl. A transaction-level model keeps
//               a queue of pending word phases and predicts every output on
//               every cycle; directed sequences add literal expectations,
//               then randomised cache agents drive traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_coherence_ctrl;

   logic             CLK = 1'b0;
   logic             nRST;
   logic [1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
   logic [1:0][31:0] iaddr, daddr, dstore;
   logic [1:0]       iwait, dwait, ccwait, ccinv;
   logic [1:0][31:0] iload, dload, ccsnoopaddr;
   logic             ramREN, ramWEN;
   logic [31:0]      ramaddr, ramstore, ramload;
   logic [1:0]       ramstate;

   always #5 CLK = ~CLK;

   bus_coherence_ctrl dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
      .ccsnoopaddr(ccsnoopaddr),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   int checks = 0;
   int errors = 0;

   // phase kinds; each queue entry is kind*2 + owning core
   localparam int K_IF = 0, K_WB = 1, K_SN = 2, K_C2C = 3, K_RD = 4;
   int ph_q[$];
   int m_last = 1, m_ilast = 1;

   logic [1:0]       e_iwait, e_dwait, e_ccwait, e_ccinv;
   logic [1:0][31:0] e_snp, e_dload, e_iload;
   logic             e_ren, e_wen;
   logic [31:0]      e_raddr, e_rstore;

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int head_kind();
      return (ph_q.size() != 0) ? ph_q[0] / 2 : -1;
   endfunction

   function automatic int head_core();
      return (ph_q.size() != 0) ? ph_q[0] % 2 : 0;
   endfunction

   // predicted outputs for the current cycle from the head phase and inputs
   task automatic model_eval();
      int k, c, o;
      e_iwait = 2'b11; e_dwait = 2'b11; e_ccwait = 2'b00; e_ccinv = 2'b00;
      e_snp = '0; e_ren = 1'b0; e_wen = 1'b0; e_raddr = '0; e_rstore = '0;
      e_dload = {ramload, ramload}; e_iload = {ramload, ramload};
      if (nRST && ph_q.size() != 0) begin
         k = head_kind(); c = head_core(); o = 1 - c;
         if (k == K_IF) begin
            e_ren = 1'b1; e_raddr = iaddr[c];
            if (ramstate == 2'd2) e_iwait[c] = 1'b0;
         end else if (k == K_WB) begin
            e_wen = 1'b1; e_raddr = daddr[c]; e_rstore = dstore[c];
            if (ramstate == 2'd2) e_dwait[c] = 1'b0;
         end else if (k == K_RD) begin
            e_ren = 1'b1; e_raddr = daddr[c];
            if (ramstate == 2'd2) e_dwait[c] = 1'b0;
         end else begin
            e_ccwait[o] = 1'b1; e_snp[o] = daddr[c]; e_ccinv[o] = ccwrite[c];
            if (k == K_C2C) begin
               e_wen = 1'b1; e_raddr = daddr[o]; e_rstore = dstore[o];
               e_dload[c] = dstore[o];
               if (ramstate == 2'd2) e_dwait = 2'b00;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("iwait", iwait, e_iwait);
      check("dwait", dwait, e_dwait);
      check("ccwait", ccwait, e_ccwait);
      check("ccinv", ccinv, e_ccinv);
      check("ccsnoopaddr", ccsnoopaddr, e_snp);
      check("ramREN", ramREN, e_ren);
      check("ramWEN", ramWEN, e_wen);
      check("ramaddr", ramaddr, e_raddr);
      check("ramstore", ramstore, e_rstore);
      check("dload", dload, e_dload);
      check("iload", iload, e_iload);
   endtask

   // advance the model across a clock edge using the sampled inputs
   task automatic model_update();
      int dr, p, k, c;
      if (!nRST) begin
         ph_q.delete(); m_last = 1; m_ilast = 1;
      end else if (ph_q.size() == 0) begin
         dr = int'(dREN | dWEN);
         if (dr != 0) begin
            p = (dr == 3) ? 1 - m_last : ((dr == 2) ? 1 : 0);
            m_last = p;
            if (dWEN[p] && !cctrans[p]) ph_q.push_back(K_WB * 2 + p);
            else if (dREN[p] && cctrans[p]) ph_q.push_back(K_SN * 2 + p);
            else if (dREN[p]) begin
               ph_q.push_back(K_RD * 2 + p); ph_q.push_back(K_RD * 2 + p);
            end else ph_q.push_back(K_WB * 2 + p);
         end else if (iREN != 2'b00) begin
            p = (iREN == 2'b11) ? 1 - m_ilast : ((iREN == 2'b10) ? 1 : 0);
            m_ilast = p;
            ph_q.push_back(K_IF * 2 + p);
         end
      end else begin
         k = head_kind(); c = head_core();
         if (k == K_SN) begin
            void'(ph_q.pop_front());
            k = (cctrans[1-c] && ccwrite[1-c]) ? K_C2C : K_RD;
            ph_q.push_back(k * 2 + c); ph_q.push_back(k * 2 + c);
         end else if (ramstate == 2'd2) begin
            void'(ph_q.pop_front());
         end
      end
   endtask

   // called one time unit after a rising edge with this cycle's inputs set
   task automatic half_a();
      #3;
      model_eval();
      compare_all();
   endtask

   task automatic half_b();
      @(posedge CLK);
      model_update();
      #1;
   endtask

   task automatic step();
      half_a();
      half_b();
   endtask

   task automatic clear_inputs();
      nRST = 1'b1; iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
      iaddr = '0; daddr = '0; dstore = '0; ramstate = 2'd2; ramload = $urandom;
   endtask

   // randomised cache agents
   int          ia_act[2], da_act[2], da_kind[2], da_word[2], da_ccw[2];
   int          sn_mod[2], sn_word[2];
   logic [31:0] ia_addr[2], da_base[2], sn_base[2];
   logic [31:0] da_data[2][2], sn_data[2][2];

   function automatic bit is_snooped(int i);
      return (head_kind() == K_SN || head_kind() == K_C2C) && head_core() != i;
   endfunction

   task automatic drive_agents();
      for (int i = 0; i < 2; i++) begin
         if (is_snooped(i) && head_kind() == K_SN) begin
            sn_mod[i] = int'($urandom_range(0, 1));
            sn_word[i] = 0;
            sn_base[i] = da_base[1-i];
            sn_data[i][0] = $urandom; sn_data[i][1] = $urandom;
         end
         iREN[i]  = (ia_act[i] != 0);
         iaddr[i] = ia_addr[i];
         dREN[i]  = (da_act[i] != 0) && (da_kind[i] != 0);
         dWEN[i]  = (da_act[i] != 0) && (da_kind[i] == 0);
         if (is_snooped(i)) begin
            daddr[i]   = sn_base[i] + 32'(4 * (sn_word[i] & 1));
            dstore[i]  = sn_data[i][sn_word[i] & 1];
            cctrans[i] = (sn_mod[i] != 0);
            ccwrite[i] = (sn_mod[i] != 0);
         end else begin
            daddr[i]   = da_base[i] + 32'(4 * (da_word[i] & 1));
            dstore[i]  = da_data[i][da_word[i] & 1];
            cctrans[i] = (da_act[i] != 0) && (da_kind[i] == 2);
            ccwrite[i] = (da_act[i] != 0) && (da_kind[i] == 2) && (da_ccw[i] != 0);
         end
      end
   endtask

   // agents react to the predicted waits of this cycle
   task automatic react_agents();
      for (int i = 0; i < 2; i++) begin
         if (!nRST) begin
            ia_act[i] = 0; da_act[i] = 0;
         end else begin
            if (ia_act[i] != 0 && !e_iwait[i]) ia_act[i] = 0;
            if (is_snooped(i)) begin
               if (!e_dwait[i]) sn_word[i]++;
            end else if (da_act[i] != 0 && !e_dwait[i]) begin
               da_word[i]++;
               if (da_word[i] == ((da_kind[i] == 0) ? 1 : 2)) da_act[i] = 0;
            end
            if (ia_act[i] == 0 && $urandom_range(0, 2) == 0) begin
               ia_act[i] = 1; ia_addr[i] = {$urandom, 2'b00} & 32'h0000_FFFC;
            end
            if (da_act[i] == 0 && $urandom_range(0, 2) == 0) begin
               da_act[i]  = 1; da_word[i] = 0;
               da_kind[i] = int'($urandom_range(0, 2));
               da_ccw[i]  = int'($urandom_range(0, 1));
               da_base[i] = 32'($urandom_range(0, 7)) << 3;
               da_data[i][0] = $urandom; da_data[i][1] = $urandom;
            end
         end
      end
   endtask

   initial begin
      clear_inputs();
      #1;

      // reset held two cycles with every request asserted
      nRST = 1'b0; iREN = 2'b11; dREN = 2'b11; dWEN = 2'b11; cctrans = 2'b11;
      repeat (2) begin
         half_a();
         check("rst_iwait", iwait, 2'b11);
         check("rst_dwait", dwait, 2'b11);
         check("rst_ramREN", ramREN, 1'b0);
         check("rst_ramWEN", ramWEN, 1'b0);
         half_b();
      end

      // dcache beats icache; icache tie goes to core 0 first
      clear_inputs();
      iREN = 2'b11; iaddr[0] = 32'h100; iaddr[1] = 32'h200;
      dREN = 2'b10; daddr[1] = 32'h300;
      step();
      half_a();
      check("arb_d1_w0", dwait, 2'b01);
      check("arb_d1_addr0", ramaddr, 32'h300);
      half_b();
      daddr[1] = 32'h304;
      half_a();
      check("arb_d1_w1", dwait, 2'b01);
      check("arb_d1_addr1", ramaddr, 32'h304);
      half_b();
      dREN = 2'b00;
      step();
      half_a();
      check("arb_i0", iwait, 2'b10);
      check("arb_i0_addr", ramaddr, 32'h100);
      half_b();
      iREN = 2'b10;
      step();
      half_a();
      check("arb_i1", iwait, 2'b01);
      check("arb_i1_addr", ramaddr, 32'h200);
      half_b();
      iREN = 2'b00;

      // continuous dcache reads alternate 0,1,0,1
      dREN = 2'b11; daddr[0] = 32'h400; daddr[1] = 32'h500;
      for (int t = 0; t < 4; t++) begin
         step();
         half_a();
         check("fair_grant", dwait, (t % 2 == 0) ? 2'b10 : 2'b01);
         half_b();
         step();
      end
      dREN = 2'b00;

      // cache-to-cache transfer from modified core 1
      dREN = 2'b01; cctrans = 2'b01; daddr[0] = 32'h40;
      step();
      cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h40; dstore[1] = 32'hAAAA;
      half_a();
      check("c2c_snp_ccwait", ccwait, 2'b10);
      check("c2c_snp_addr", ccsnoopaddr[1], 32'h40);
      check("c2c_snp_ccinv", ccinv, 2'b00);
      check("c2c_snp_dwait", dwait, 2'b11);
      half_b();
      for (int w = 0; w < 2; w++) begin
         daddr[0] = 32'h40 + 32'(4 * w); daddr[1] = 32'h40 + 32'(4 * w);
         dstore[1] = (w == 0) ? 32'hAAAA : 32'hBBBB;
         half_a();
         check("c2c_wen", ramWEN, 1'b1);
         check("c2c_ramaddr", ramaddr, 32'h40 + 32'(4 * w));
         check("c2c_ramstore", ramstore, (w == 0) ? 32'hAAAA : 32'hBBBB);
         check("c2c_dload0", dload[0], (w == 0) ? 32'hAAAA : 32'hBBBB);
         check("c2c_dwait", dwait, 2'b00);
         half_b();
      end
      clear_inputs();
      step();

      // clean snoop with exclusive request, RAM stretched by BUSY
      dREN = 2'b01; cctrans = 2'b01; ccwrite = 2'b01; daddr[0] = 32'h80;
      step();
      half_a();
      check("rd_snp_ccinv", ccinv, 2'b10);
      check("rd_snp_ccwait", ccwait, 2'b10);
      half_b();
      for (int w = 0; w < 2; w++) begin
         daddr[0] = 32'h80 + 32'(4 * w);
         ramstate = 2'd1;
         repeat (3) begin
            half_a();
            check("rd_busy_dwait", dwait, 2'b11);
            check("rd_busy_ren", ramREN, 1'b1);
            half_b();
         end
         ramstate = 2'd2; ramload = 32'hC0DE_0000 + 32'(w);
         half_a();
         check("rd_dwait", dwait, 2'b10);
         check("rd_dload0", dload[0], 32'hC0DE_0000 + 32'(w));
         check("rd_ramaddr", ramaddr, 32'h80 + 32'(4 * w));
         check("rd_ccwait", ccwait, 2'b00);
         half_b();
      end
      clear_inputs();
      step();

      // reset during C2C1 aborts with no acknowledge
      dREN = 2'b01; cctrans = 2'b01; daddr[0] = 32'h60;
      step();
      cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h60; dstore[1] = 32'h1234;
      step();
      ramstate = 2'd1;
      half_a();
      check("rstc2c_hold_wen", ramWEN, 1'b1);
      half_b();
      nRST = 1'b0; ramstate = 2'd2;
      half_a();
      check("rstc2c_dwait", dwait, 2'b11);
      check("rstc2c_wen", ramWEN, 1'b0);
      half_b();
      clear_inputs();
      half_a();
      check("rstc2c_idle_ccwait", ccwait, 2'b00);
      check("rstc2c_idle_dwait", dwait, 2'b11);
      check("rstc2c_idle_wen", ramWEN, 1'b0);
      half_b();

      // randomised traffic
      for (int i = 0; i < 2; i++) begin
         ia_act[i] = 0; da_act[i] = 0; da_word[i] = 0; da_kind[i] = 0; da_ccw[i] = 0;
         sn_mod[i] = 0; sn_word[i] = 0; ia_addr[i] = '0; da_base[i] = '0; sn_base[i] = '0;
         da_data[i][0] = '0; da_data[i][1] = '0; sn_data[i][0] = '0; sn_data[i][1] = '0;
      end
      for (int cyc = 0; cyc < 4000; cyc++) begin
         nRST = ($urandom_range(0, 299) != 0);
         begin
            int r;
            r = int'($urandom_range(0, 7));
            ramstate = (r < 4) ? 2'd2 : 2'(r - 4);
         end
         ramload = $urandom;
         drive_agents();
         half_a();
         react_agents();
         half_b();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
